// File: rtl/slave_ctrl_gen.sv
// slave_ctrl_gen: bus-slave controller for the SIMD DLX card interface.
// Decodes card select plus base address, latches the register address and
// access type, inserts wait states, then drives an active-low ack of
// programmable length together with a one-cycle register strobe.
module slave_ctrl_gen #(
  parameter int unsigned            AW          = 10,
  parameter int unsigned            BASE_BITS   = 3,
  parameter logic [BASE_BITS-1:0]   BASE        = 3'b111,
  parameter int unsigned            REG_AW      = 5,
  parameter int unsigned            WAIT_CYCLES = 0,
  parameter int unsigned            ACK_LEN     = 1,
  parameter bit                     READ_EN     = 1'b1,
  parameter bit                     WRITE_EN    = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CARD_SEL,
  input  logic [AW-1:0]     AI,
  input  logic              WR_IN_N,
  output logic [REG_AW-1:0] REG_ADDR,
  output logic              SACK_N,
  output logic              REG_RE,
  output logic              REG_WE,
  output logic              BUSY
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);
  localparam logic [3:0] ACK_C  = 4'(ACK_LEN);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [REG_AW-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;      // latched type: 1 = write
  logic                sack_n_q, sack_n_d;
  logic                re_q, re_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                req, allowed;

  // Request decode, next-state and registered-output computation
  always_comb begin
    req      = CARD_SEL && (AI[AW-1 -: BASE_BITS] == BASE);
    allowed  = (WR_IN_N && READ_EN) || (!WR_IN_N && WRITE_EN);
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (allowed) begin
            addr_d = AI[REG_AW-1:0];
            wr_d   = !WR_IN_N;
            if (WAIT_C == 4'd0) begin
              state_d = ACK;
              cnt_d   = 4'd1;
              re_d    = WR_IN_N;
              we_d    = !WR_IN_N;
            end else begin
              state_d = WAIT;
              cnt_d   = WAIT_C;
            end
          end else begin
            // Disallowed access: park until the request is released
            state_d = HOLD;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          // Countdown reaches zero on this edge; ack counter starts at 1
          state_d = ACK;
          cnt_d   = 4'd1;
          re_d    = !wr_q;
          we_d    = wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q >= ACK_C) begin
          state_d = HOLD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (!req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    sack_n_d = (state_d != ACK);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      sack_n_q <= 1'b1;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      sack_n_q <= sack_n_d;
      re_q     <= re_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
    end
  end

  assign REG_ADDR = addr_q;
  assign SACK_N   = sack_n_q;
  assign REG_RE   = re_q;
  assign REG_WE   = we_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_slave_ctrl_gen.sv
// Bench for slave_ctrl_gen: three configurations driven one at a time.
// Expected outputs after each edge are queued when stimulus is applied and
// compared against the DUT on the following falling edge.
module tb_slave_ctrl_gen;

  logic       clk;
  logic       rst   [3];
  logic       cs    [3];
  logic [9:0] ai    [3];
  logic       wr    [3];
  logic [4:0] ra    [3];
  logic       sack  [3];
  logic       re    [3];
  logic       we    [3];
  logic       busy  [3];

  int n_chk  = 0;
  int n_pass = 0;
  int step   = 0;

  typedef struct {
    int         id;
    logic       sack, re, we, busy;
    logic [4:0] addr;
  } exp_t;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: defaults (read only, no wait, 1-cycle ack)
  slave_ctrl_gen u0 (
    .CLK(clk), .RESET(rst[0]), .CARD_SEL(cs[0]), .AI(ai[0]), .WR_IN_N(wr[0]),
    .REG_ADDR(ra[0]), .SACK_N(sack[0]), .REG_RE(re[0]), .REG_WE(we[0]), .BUSY(busy[0]));

  // u1: 3 wait states, 2-cycle ack, writes acknowledged
  slave_ctrl_gen #(.WAIT_CYCLES(3), .ACK_LEN(2), .WRITE_EN(1'b1)) u1 (
    .CLK(clk), .RESET(rst[1]), .CARD_SEL(cs[1]), .AI(ai[1]), .WR_IN_N(wr[1]),
    .REG_ADDR(ra[1]), .SACK_N(sack[1]), .REG_RE(re[1]), .REG_WE(we[1]), .BUSY(busy[1]));

  // u2: 4 wait states, 4-cycle ack
  slave_ctrl_gen #(.WAIT_CYCLES(4), .ACK_LEN(4)) u2 (
    .CLK(clk), .RESET(rst[2]), .CARD_SEL(cs[2]), .AI(ai[2]), .WR_IN_N(wr[2]),
    .REG_ADDR(ra[2]), .SACK_N(sack[2]), .REG_RE(re[2]), .REG_WE(we[2]), .BUSY(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply inputs to one instance, queue the expected post-edge outputs,
  // advance one clock and compare on the falling edge.
  task automatic cyc(input int id, input bit r, input bit c, input logic [9:0] a,
                     input bit w, input bit es, input bit er, input bit ew,
                     input bit eb, input logic [4:0] ea);
    exp_t e;
    rst[id] = r; cs[id] = c; ai[id] = a; wr[id] = w;
    e.id = id; e.sack = es; e.re = er; e.we = ew; e.busy = eb; e.addr = ea;
    sb.push_back(e);
    step++;
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("u%0d s%0d sack", e.id, step), 32'(sack[e.id]), 32'(e.sack));
    chk($sformatf("u%0d s%0d re",   e.id, step), 32'(re[e.id]),   32'(e.re));
    chk($sformatf("u%0d s%0d we",   e.id, step), 32'(we[e.id]),   32'(e.we));
    chk($sformatf("u%0d s%0d busy", e.id, step), 32'(busy[e.id]), 32'(e.busy));
    chk($sformatf("u%0d s%0d addr", e.id, step), 32'(ra[e.id]),   32'(e.addr));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; cs[i] = 1'b1; ai[i] = 10'h385; wr[i] = 1'b1;
    end
    // Reset dominates a live request
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d rst sack", i), 32'(sack[i]), 32'd1);
      chk($sformatf("u%0d rst re",   i), 32'(re[i]),   32'd0);
      chk($sformatf("u%0d rst we",   i), 32'(we[i]),   32'd0);
      chk($sformatf("u%0d rst busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("u%0d rst addr", i), 32'(ra[i]),   32'd0);
      rst[i] = 1'b0; cs[i] = 1'b0;
    end

    // ---- u0: single pulse for a held read, then re-arm
    //       id r cs ai       w  sack re we busy addr
    cyc(0, 0, 1, 10'h385, 1, 0, 1, 0, 1, 5'h05);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 10'h385, 1, 1, 0, 0, 1, 5'h05);
    cyc(0, 0, 0, 10'h385, 1, 1, 0, 0, 0, 5'h05);
    cyc(0, 0, 1, 10'h385, 1, 0, 1, 0, 1, 5'h05);
    cyc(0, 0, 1, 10'h385, 1, 1, 0, 0, 1, 5'h05);
    cyc(0, 0, 0, 10'h385, 1, 1, 0, 0, 0, 5'h05);
    // base mismatch and no card select: nothing happens
    cyc(0, 0, 1, 10'h185, 1, 1, 0, 0, 0, 5'h05);
    cyc(0, 0, 1, 10'h185, 1, 1, 0, 0, 0, 5'h05);
    cyc(0, 0, 0, 10'h385, 1, 1, 0, 0, 0, 5'h05);
    // write with writes disabled: busy but silent until release
    cyc(0, 0, 1, 10'h3A0, 0, 1, 0, 0, 1, 5'h05);
    cyc(0, 0, 1, 10'h3A0, 0, 1, 0, 0, 1, 5'h05);
    cyc(0, 0, 0, 10'h3A0, 0, 1, 0, 0, 0, 5'h05);

    // ---- u1: read with 3 waits / 2-cycle ack; type and address changes ignored
    cyc(1, 0, 1, 10'h385, 1, 1, 0, 0, 1, 5'h05);   // edge k
    cyc(1, 0, 1, 10'h39F, 0, 1, 0, 0, 1, 5'h05);   // k+1
    cyc(1, 0, 1, 10'h39F, 0, 1, 0, 0, 1, 5'h05);   // k+2
    cyc(1, 0, 1, 10'h39F, 0, 0, 1, 0, 1, 5'h05);   // k+3 ack, read strobe
    cyc(1, 0, 1, 10'h39F, 0, 0, 0, 0, 1, 5'h05);   // k+4 ack
    cyc(1, 0, 1, 10'h39F, 0, 1, 0, 0, 1, 5'h05);   // hold
    cyc(1, 0, 0, 10'h39F, 0, 1, 0, 0, 0, 5'h05);   // release
    // write accepted
    cyc(1, 0, 1, 10'h3A0, 0, 1, 0, 0, 1, 5'h00);
    cyc(1, 0, 1, 10'h3A0, 0, 1, 0, 0, 1, 5'h00);
    cyc(1, 0, 1, 10'h3A0, 0, 1, 0, 0, 1, 5'h00);
    cyc(1, 0, 1, 10'h3A0, 0, 0, 0, 1, 1, 5'h00);
    cyc(1, 0, 1, 10'h3A0, 0, 0, 0, 0, 1, 5'h00);
    cyc(1, 0, 1, 10'h3A0, 0, 1, 0, 0, 1, 5'h00);
    cyc(1, 0, 0, 10'h3A0, 0, 1, 0, 0, 0, 5'h00);

    // ---- u2: drop during wait aborts silently
    cyc(2, 0, 1, 10'h385, 1, 1, 0, 0, 1, 5'h05);   // k
    cyc(2, 0, 1, 10'h385, 1, 1, 0, 0, 1, 5'h05);   // k+1
    cyc(2, 0, 0, 10'h385, 1, 1, 0, 0, 0, 5'h05);   // k+2 drop
    cyc(2, 0, 0, 10'h385, 1, 1, 0, 0, 0, 5'h05);
    // new request, reset in the middle of the ack
    cyc(2, 0, 1, 10'h3E2, 1, 1, 0, 0, 1, 5'h02);   // k
    for (int i = 0; i < 3; i++) cyc(2, 0, 1, 10'h3E2, 1, 1, 0, 0, 1, 5'h02);
    cyc(2, 0, 1, 10'h3E2, 1, 0, 1, 0, 1, 5'h02);   // k+4 ack start
    cyc(2, 0, 1, 10'h3E2, 1, 0, 0, 0, 1, 5'h02);
    cyc(2, 1, 1, 10'h3E2, 1, 1, 0, 0, 0, 5'h00);   // reset edge
    // after reset: normal transaction with full 4-cycle ack
    cyc(2, 0, 1, 10'h3E2, 1, 1, 0, 0, 1, 5'h02);
    for (int i = 0; i < 3; i++) cyc(2, 0, 1, 10'h3E2, 1, 1, 0, 0, 1, 5'h02);
    cyc(2, 0, 1, 10'h3E2, 1, 0, 1, 0, 1, 5'h02);
    for (int i = 0; i < 3; i++) cyc(2, 0, 1, 10'h3E2, 1, 0, 0, 0, 1, 5'h02);
    cyc(2, 0, 1, 10'h3E2, 1, 1, 0, 0, 1, 5'h02);   // hold
    cyc(2, 0, 0, 10'h3E2, 1, 1, 0, 0, 0, 5'h02);   // release

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
